// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : move_sequencer
// Description : Turn-level chess move controller. Collects a source and a
//               destination selection, asks the board validator once, then
//               commits the move as two board-RAM writes and flips the turn.
// Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [3:0]  EMPTY_CODE     = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sel_valid_i,
  input  logic [2:0]            sel_x_i,
  input  logic [2:0]            sel_y_i,
  input  logic                  cancel_i,
  input  logic [7:0][7:0][3:0]  board_i,      // indexed [row y][column x]
  output logic                  val_req_o,
  output logic [2:0]            val_old_x_o,
  output logic [2:0]            val_old_y_o,
  output logic [2:0]            val_new_x_o,
  output logic [2:0]            val_new_y_o,
  output logic [3:0]            val_piece_o,
  input  logic                  val_done_i,
  input  logic                  val_ok_i,
  output logic                  wr_en_o,
  output logic [2:0]            wr_x_o,
  output logic [2:0]            wr_y_o,
  output logic [3:0]            wr_data_o,
  output logic                  turn_o,
  output logic                  src_active_o,
  output logic [2:0]            src_x_o,
  output logic [2:0]            src_y_o,
  output logic                  busy_o,
  output logic                  move_accepted_o,
  output logic                  move_rejected_o,
  output logic                  timed_out_o,
  output logic [3:0]            captured_o,
  output logic                  game_over_o
);

  // Counter value (cycles since val_req) at which the wait is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HAVE_SRC   = 3'd1,
    S_REQ        = 3'd2,
    S_WAIT_VAL   = 3'd3,
    S_COMMIT_DST = 3'd4,
    S_COMMIT_SRC = 3'd5,
    S_REJECT     = 3'd6
  } state_t;

  state_t      state_q;
  logic        turn_q, src_active_q, game_over_q;
  logic [2:0]  src_x_q, src_y_q, dst_x_q, dst_y_q;
  logic [3:0]  piece_q, dst_code_q, captured_q;
  logic        val_req_q, wr_en_q;
  logic [2:0]  wr_x_q, wr_y_q;
  logic [3:0]  wr_data_q;
  logic        move_accepted_q, move_rejected_q, timed_out_q;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  sel_code;
  logic        sel_own, sel_is_src, dst_is_king;

  // Decode the selected square: its piece code and whether it belongs to the side to move.
  always_comb begin
    sel_code    = board_i[sel_y_i][sel_x_i];
    sel_own     = turn_q ? ((sel_code >= 4'd6) && (sel_code <= 4'd11)) : (sel_code <= 4'd5);
    sel_is_src  = (sel_x_i == src_x_q) && (sel_y_i == src_y_q);
    dst_is_king = (dst_code_q == 4'd4) || (dst_code_q == 4'd10);
    cnt_d       = cnt_q + 8'd1;
  end

  // Move sequencing FSM; every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      turn_q          <= 1'b0;
      src_active_q    <= 1'b0;
      game_over_q     <= 1'b0;
      src_x_q         <= 3'd0;
      src_y_q         <= 3'd0;
      dst_x_q         <= 3'd0;
      dst_y_q         <= 3'd0;
      piece_q         <= 4'd0;
      dst_code_q      <= 4'd0;
      captured_q      <= EMPTY_CODE;
      val_req_q       <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_x_q          <= 3'd0;
      wr_y_q          <= 3'd0;
      wr_data_q       <= 4'd0;
      move_accepted_q <= 1'b0;
      move_rejected_q <= 1'b0;
      timed_out_q     <= 1'b0;
      cnt_q           <= 8'd0;
    end else begin
      val_req_q       <= 1'b0;
      wr_en_q         <= 1'b0;
      move_accepted_q <= 1'b0;
      move_rejected_q <= 1'b0;
      timed_out_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // After a king capture the board is frozen until reset.
          if (sel_valid_i && !game_over_q && sel_own) begin
            src_x_q      <= sel_x_i;
            src_y_q      <= sel_y_i;
            piece_q      <= sel_code;
            src_active_q <= 1'b1;
            state_q      <= S_HAVE_SRC;
          end
        end
        S_HAVE_SRC: begin
          if (cancel_i) begin
            src_active_q <= 1'b0;
            state_q      <= S_IDLE;
          end else if (sel_valid_i) begin
            if (sel_is_src) begin
              src_active_q <= 1'b0;
              state_q      <= S_IDLE;
            end else if (sel_own) begin
              src_x_q <= sel_x_i;
              src_y_q <= sel_y_i;
              piece_q <= sel_code;
            end else begin
              dst_x_q    <= sel_x_i;
              dst_y_q    <= sel_y_i;
              dst_code_q <= sel_code;
              val_req_q  <= 1'b1;
              cnt_q      <= 8'd0;
              state_q    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt_q   <= cnt_d;
          state_q <= S_WAIT_VAL;
        end
        S_WAIT_VAL: begin
          cnt_q <= cnt_d;
          // A done strobe in the final counted cycle still takes precedence.
          if (val_done_i) begin
            if (val_ok_i) begin
              wr_en_q   <= 1'b1;
              wr_x_q    <= dst_x_q;
              wr_y_q    <= dst_y_q;
              wr_data_q <= piece_q;
              state_q   <= S_COMMIT_DST;
            end else begin
              move_rejected_q <= 1'b1;
              state_q         <= S_REJECT;
            end
          end else if (cnt_q == CNT_LAST) begin
            move_rejected_q <= 1'b1;
            timed_out_q     <= 1'b1;
            state_q         <= S_REJECT;
          end
        end
        S_COMMIT_DST: begin
          wr_en_q         <= 1'b1;
          wr_x_q          <= src_x_q;
          wr_y_q          <= src_y_q;
          wr_data_q       <= EMPTY_CODE;
          move_accepted_q <= 1'b1;
          captured_q      <= dst_code_q;
          state_q         <= S_COMMIT_SRC;
        end
        S_COMMIT_SRC: begin
          turn_q       <= ~turn_q;
          src_active_q <= 1'b0;
          if (dst_is_king) begin
            game_over_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        S_REJECT: begin
          src_active_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign val_req_o       = val_req_q;
  assign val_old_x_o     = src_x_q;
  assign val_old_y_o     = src_y_q;
  assign val_new_x_o     = dst_x_q;
  assign val_new_y_o     = dst_y_q;
  assign val_piece_o     = piece_q;
  assign wr_en_o         = wr_en_q;
  assign wr_x_o          = wr_x_q;
  assign wr_y_o          = wr_y_q;
  assign wr_data_o       = wr_data_q;
  assign turn_o          = turn_q;
  assign src_active_o    = src_active_q;
  assign src_x_o         = src_x_q;
  assign src_y_o         = src_y_q;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_HAVE_SRC);
  assign move_accepted_o = move_accepted_q;
  assign move_rejected_o = move_rejected_q;
  assign timed_out_o     = timed_out_q;
  assign captured_o      = captured_q;
  assign game_over_o     = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_sequencer
// Description : Self-checking bench for move_sequencer: directed scenarios
//               plus randomized play checked against a rules-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

  localparam int         TO    = 64;
  localparam logic [3:0] EMPTY = 4'hF;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sel_valid = 1'b0;
  logic [2:0]           sel_x = 3'd0, sel_y = 3'd0;
  logic                 cancel = 1'b0;
  logic [7:0][7:0][3:0] board;
  logic                 val_done = 1'b0, val_ok = 1'b0;
  logic                 val_req_o, wr_en_o, turn_o, src_active_o, busy_o;
  logic [2:0]           val_old_x_o, val_old_y_o, val_new_x_o, val_new_y_o;
  logic [2:0]           wr_x_o, wr_y_o, src_x_o, src_y_o;
  logic [3:0]           val_piece_o, wr_data_o, captured_o;
  logic                 move_accepted_o, move_rejected_o, timed_out_o, game_over_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_count = 0;
  logic [9:0]  wq[$];          // observed writes {x, y, data}
  int          exp_board[8][8];

  always #5 clk = ~clk;

  move_sequencer #(.TIMEOUT_CYCLES(TO), .EMPTY_CODE(EMPTY)) dut (
    .clk(clk), .reset_n(reset_n),
    .sel_valid_i(sel_valid), .sel_x_i(sel_x), .sel_y_i(sel_y), .cancel_i(cancel),
    .board_i(board),
    .val_req_o(val_req_o), .val_old_x_o(val_old_x_o), .val_old_y_o(val_old_y_o),
    .val_new_x_o(val_new_x_o), .val_new_y_o(val_new_y_o), .val_piece_o(val_piece_o),
    .val_done_i(val_done), .val_ok_i(val_ok),
    .wr_en_o(wr_en_o), .wr_x_o(wr_x_o), .wr_y_o(wr_y_o), .wr_data_o(wr_data_o),
    .turn_o(turn_o), .src_active_o(src_active_o), .src_x_o(src_x_o), .src_y_o(src_y_o),
    .busy_o(busy_o), .move_accepted_o(move_accepted_o), .move_rejected_o(move_rejected_o),
    .timed_out_o(timed_out_o), .captured_o(captured_o), .game_over_o(game_over_o)
  );

  function automatic bit is_own(int code, int t);
    return (t != 0) ? (code >= 6 && code <= 11) : (code >= 0 && code <= 5);
  endfunction

  // One clock: the board RAM absorbs writes mid-cycle, then we land 1ns after the edge.
  task automatic step();
    @(negedge clk);
    if (val_req_o) req_count++;
    if (wr_en_o) begin
      board[wr_y_o][wr_x_o] = wr_data_o;
      wq.push_back({wr_x_o, wr_y_o, wr_data_o});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int x, input int y);
    sel_valid = 1'b1; sel_x = 3'(x); sel_y = 3'(y);
    step();
    sel_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sel_valid = 1'b0; cancel = 1'b0; val_done = 1'b0; val_ok = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    wq.delete();
  endtask

  task automatic set_standard();
    int back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        case (y)
          0: board[y][x] = 4'(back[x]);
          1: board[y][x] = 4'd5;
          6: board[y][x] = 4'd11;
          7: board[y][x] = 4'(back[x] + 6);
          default: board[y][x] = EMPTY;
        endcase
      end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) board[y][x] = EMPTY;
  endtask

  // Plays the validator from the val_req cycle. mode 0 = never answers,
  // 1 = answers illegal, 2 = answers legal; done is raised lat cycles after val_req.
  task automatic drive_validator(input int mode, input int lat, input bit noise,
                                 output int n, output bit acc, output bit rej,
                                 output bit to, output logic [3:0] cap);
    n = 0; acc = 0; rej = 0; to = 0; cap = 4'd0;
    while (n < 300) begin
      val_done = (mode != 0) && (n == lat);
      val_ok   = val_done && (mode == 2);
      if (noise) begin
        sel_valid = ($urandom_range(0, 2) == 0);
        sel_x     = 3'($urandom_range(0, 7));
        sel_y     = 3'($urandom_range(0, 7));
        cancel    = ($urandom_range(0, 3) == 0);
      end
      step();
      n++;
      val_done = 0; val_ok = 0; sel_valid = 0; cancel = 0;
      if (move_accepted_o || move_rejected_o) begin
        acc = move_accepted_o; rej = move_rejected_o; to = timed_out_o; cap = captured_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    n_tests++;
    if (turn_o !== 1'b0 || game_over_o !== 1'b0 || src_active_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: turn=%b go=%b src_act=%b busy=%b, expected all 0",
               turn_o, game_over_o, src_active_o, busy_o);
    end
    n_tests++;
    if ({val_req_o, wr_en_o, move_accepted_o, move_rejected_o, timed_out_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {val_req_o, wr_en_o, move_accepted_o, move_rejected_o, timed_out_o});
    end
    n_tests++;
    if (captured_o !== EMPTY || {src_x_o, src_y_o, val_new_x_o, val_new_y_o, wr_x_o, wr_y_o} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_values: captured=%h coords=%h expected F / 0", captured_o,
               {src_x_o, src_y_o, val_new_x_o, val_new_y_o, wr_x_o, wr_y_o});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_pawn_move();
    int n; bit acc, rej, to; logic [3:0] cap;
    do_reset();
    set_standard();
    select(4, 1);
    n_tests++;
    if (src_active_o !== 1'b1 || src_x_o !== 3'd4 || src_y_o !== 3'd1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pawn_src: act=%b src=(%0d,%0d) busy=%b expected 1 (4,1) 0",
               src_active_o, src_x_o, src_y_o, busy_o);
    end
    select(4, 3);
    n_tests++;
    if (val_req_o !== 1'b1 || busy_o !== 1'b1 ||
        {val_old_x_o, val_old_y_o, val_new_x_o, val_new_y_o, val_piece_o} !== {3'd4, 3'd1, 3'd4, 3'd3, 4'd5}) begin
      n_fail++;
      $display("FAIL pawn_req: req=%b busy=%b move=(%0d,%0d)->(%0d,%0d) piece=%0d expected 1 1 (4,1)->(4,3) 5",
               val_req_o, busy_o, val_old_x_o, val_old_y_o, val_new_x_o, val_new_y_o, val_piece_o);
    end
    drive_validator(2, 3, 1'b0, n, acc, rej, to, cap);
    n_tests++;
    if (n != 5 || !acc || rej || cap !== EMPTY) begin
      n_fail++;
      $display("FAIL pawn_accept: cycles=%0d acc=%b rej=%b cap=%h expected 5 1 0 F", n, acc, rej, cap);
    end
    step();
    n_tests++;
    if (wq.size() != 2 || wq[0] !== {3'd4, 3'd3, 4'd5} || wq[1] !== {3'd4, 3'd1, EMPTY}) begin
      n_fail++;
      $display("FAIL pawn_writes: count=%0d first=%h second=%h expected 2 %h %h", wq.size(),
               (wq.size() > 0) ? wq[0] : 10'h0, (wq.size() > 1) ? wq[1] : 10'h0,
               {3'd4, 3'd3, 4'd5}, {3'd4, 3'd1, EMPTY});
    end
    n_tests++;
    if (turn_o !== 1'b1 || src_active_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pawn_after: turn=%b act=%b busy=%b expected 1 0 0", turn_o, src_active_o, busy_o);
    end
  endtask

  task automatic test_ignore_opponent();
    do_reset();
    set_standard();
    select(1, 7);
    n_tests++;
    if (src_active_o !== 1'b0 || val_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_opp: act=%b req=%b busy=%b expected 0 0 0", src_active_o, val_req_o, busy_o);
    end
  endtask

  task automatic test_relatch_cancel();
    select(0, 0);
    select(1, 0);
    n_tests++;
    if (src_active_o !== 1'b1 || src_x_o !== 3'd1 || src_y_o !== 3'd0 || val_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL relatch: act=%b src=(%0d,%0d) req=%b expected 1 (1,0) 0",
               src_active_o, src_x_o, src_y_o, val_req_o);
    end
    // cancel wins over a simultaneous destination pick
    cancel = 1'b1; sel_valid = 1'b1; sel_x = 3'd4; sel_y = 3'd4;
    step();
    cancel = 1'b0; sel_valid = 1'b0;
    n_tests++;
    if (src_active_o !== 1'b0 || val_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel: act=%b req=%b busy=%b expected 0 0 0", src_active_o, val_req_o, busy_o);
    end
    select(1, 0);
    select(1, 0);
    n_tests++;
    if (src_active_o !== 1'b0 || val_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL deselect: act=%b req=%b expected 0 0", src_active_o, val_req_o);
    end
  endtask

  task automatic test_timeout();
    int n; bit acc, rej, to; logic [3:0] cap;
    wq.delete();
    select(4, 1); select(4, 3);
    drive_validator(0, 0, 1'b0, n, acc, rej, to, cap);
    n_tests++;
    if (n != TO || !rej || !to || acc) begin
      n_fail++;
      $display("FAIL timeout: cycles=%0d rej=%b to=%b acc=%b expected %0d 1 1 0", n, rej, to, acc, TO);
    end
    step();
    n_tests++;
    if (wq.size() != 0 || turn_o !== 1'b0 || src_active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: writes=%0d turn=%b act=%b expected 0 0 0", wq.size(), turn_o, src_active_o);
    end
    // done arriving in the very last counted cycle beats the timeout
    select(4, 1); select(4, 3);
    drive_validator(1, TO - 1, 1'b0, n, acc, rej, to, cap);
    n_tests++;
    if (n != TO || !rej || to || acc) begin
      n_fail++;
      $display("FAIL timeout_edge: cycles=%0d rej=%b to=%b acc=%b expected %0d 1 0 0", n, rej, to, acc, TO);
    end
    step();
  endtask

  task automatic test_reject_noise();
    int n, rc0; bit acc, rej, to; logic [3:0] cap;
    wq.delete();
    select(4, 1); select(4, 4);
    rc0 = req_count;
    drive_validator(1, 2, 1'b1, n, acc, rej, to, cap);
    n_tests++;
    if (n != 3 || !rej || to || acc) begin
      n_fail++;
      $display("FAIL reject: cycles=%0d rej=%b to=%b acc=%b expected 3 1 0 0", n, rej, to, acc);
    end
    step(); step();
    n_tests++;
    if (wq.size() != 0 || req_count != rc0 + 1 || turn_o !== 1'b0 || src_active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_after: writes=%0d reqs=%0d turn=%b act=%b expected 0 1 0 0",
               wq.size(), req_count - rc0, turn_o, src_active_o);
    end
  endtask

  task automatic test_king_capture_and_reset();
    int n; bit acc, rej, to; logic [3:0] cap;
    do_reset();
    clear_board();
    board[3][3] = 4'd3;
    board[6][3] = 4'd10;
    board[0][0] = 4'd6;
    select(3, 3); select(3, 6);
    drive_validator(2, 1, 1'b0, n, acc, rej, to, cap);
    n_tests++;
    if (n != 3 || !acc || cap !== 4'd10) begin
      n_fail++;
      $display("FAIL king_capture: cycles=%0d acc=%b cap=%0d expected 3 1 10", n, acc, cap);
    end
    step();
    n_tests++;
    if (game_over_o !== 1'b1 || turn_o !== 1'b1) begin
      n_fail++;
      $display("FAIL game_over: go=%b turn=%b expected 1 1", game_over_o, turn_o);
    end
    select(0, 0);
    n_tests++;
    if (src_active_o !== 1'b0 || game_over_o !== 1'b1) begin
      n_fail++;
      $display("FAIL game_over_ignore: act=%b go=%b expected 0 1", src_active_o, game_over_o);
    end
    // fresh game; white moves, black starts a move, reset lands mid-wait
    do_reset();
    set_standard();
    select(4, 1); select(4, 3);
    drive_validator(2, 1, 1'b0, n, acc, rej, to, cap);
    step();
    select(4, 6); select(4, 4);
    step(); step();
    wq.delete();
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (turn_o !== 1'b0 || busy_o !== 1'b0 || src_active_o !== 1'b0 || game_over_o !== 1'b0 || wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: turn=%b busy=%b act=%b go=%b wr=%b expected all 0",
               turn_o, busy_o, src_active_o, game_over_o, wr_en_o);
    end
    step(); step();
    reset_n = 1'b1;
    val_done = 1'b1; val_ok = 1'b1;
    step();
    val_done = 1'b0; val_ok = 1'b0;
    step(); step();
    n_tests++;
    if (wq.size() != 0 || busy_o !== 1'b0 || turn_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: writes=%0d busy=%b turn=%b expected 0 0 0", wq.size(), busy_o, turn_o);
    end
  endtask

  task automatic test_random();
    int m_turn, m_active, m_sx, m_sy, m_piece;
    int x, y, code, r, mode, lat, n, rc0, exp_n, bad;
    bit acc, rej, to;
    logic [3:0] cap;
    do_reset();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++) begin
        r = $urandom_range(0, 15);
        if (r == 4 || r == 10) r = 15;
        exp_board[yy][xx] = r;
        board[yy][xx] = 4'(r);
      end
    m_turn = 0; m_active = 0; m_sx = 0; m_sy = 0; m_piece = 0;
    for (int it = 0; it < 60; it++) begin
      if (m_active != 0 && $urandom_range(0, 7) == 0) begin
        cancel = 1'b1; sel_valid = 1'($urandom_range(0, 1));
        sel_x = 3'($urandom_range(0, 7)); sel_y = 3'($urandom_range(0, 7));
        step();
        cancel = 1'b0; sel_valid = 1'b0;
        m_active = 0;
        n_tests++;
        if (src_active_o !== 1'b0 || val_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_cancel it=%0d: act=%b req=%b expected 0 0", it, src_active_o, val_req_o);
        end
        continue;
      end
      x = $urandom_range(0, 7); y = $urandom_range(0, 7);
      if (m_active == 0 || $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 16; k++) begin
          if (is_own(exp_board[y][x], m_turn)) break;
          x = $urandom_range(0, 7); y = $urandom_range(0, 7);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        x = m_sx; y = m_sy;
      end
      code = exp_board[y][x];
      select(x, y);
      if (m_active == 0 || (x == m_sx && y == m_sy) || is_own(code, m_turn)) begin
        if (m_active == 0) begin
          if (is_own(code, m_turn)) begin m_active = 1; m_sx = x; m_sy = y; m_piece = code; end
        end else if (x == m_sx && y == m_sy) begin
          m_active = 0;
        end else begin
          m_sx = x; m_sy = y; m_piece = code;
        end
        n_tests++;
        if (src_active_o !== 1'(m_active) || val_req_o !== 1'b0 ||
            (m_active != 0 && (src_x_o !== 3'(m_sx) || src_y_o !== 3'(m_sy)))) begin
          n_fail++;
          $display("FAIL rnd_select it=%0d: act=%b src=(%0d,%0d) req=%b expected %0d (%0d,%0d) 0",
                   it, src_active_o, src_x_o, src_y_o, val_req_o, m_active, m_sx, m_sy);
        end
        continue;
      end
      n_tests++;
      if (val_req_o !== 1'b1 || {val_old_x_o, val_old_y_o, val_new_x_o, val_new_y_o, val_piece_o} !==
          {3'(m_sx), 3'(m_sy), 3'(x), 3'(y), 4'(m_piece)}) begin
        n_fail++;
        $display("FAIL rnd_req it=%0d: req=%b move=(%0d,%0d)->(%0d,%0d) p=%0d expected 1 (%0d,%0d)->(%0d,%0d) p=%0d",
                 it, val_req_o, val_old_x_o, val_old_y_o, val_new_x_o, val_new_y_o, val_piece_o,
                 m_sx, m_sy, x, y, m_piece);
      end
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? 0 : (r <= 3) ? 1 : 2;
      lat  = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(1, 6);
      wq.delete();
      rc0 = req_count;
      drive_validator(mode, lat, 1'($urandom_range(0, 1)), n, acc, rej, to, cap);
      exp_n = (mode == 0) ? TO : (mode == 1) ? lat + 1 : lat + 2;
      n_tests++;
      if (n != exp_n || acc != (mode == 2) || rej != (mode != 2) || to != (mode == 0) ||
          (mode == 2 && cap !== 4'(code))) begin
        n_fail++;
        $display("FAIL rnd_result it=%0d mode=%0d: cycles=%0d acc=%b rej=%b to=%b cap=%0d expected %0d %0d %0d %0d %0d",
                 it, mode, n, acc, rej, to, cap, exp_n, mode == 2, mode != 2, mode == 0, code);
      end
      step();
      if (mode == 2) begin
        exp_board[y][x] = m_piece;
        exp_board[m_sy][m_sx] = 15;
        m_turn = 1 - m_turn;
      end
      bad = 0;
      for (int yy = 0; yy < 8; yy++)
        for (int xx = 0; xx < 8; xx++)
          if (board[yy][xx] !== 4'(exp_board[yy][xx])) bad++;
      n_tests++;
      if (bad != 0 || wq.size() != ((mode == 2) ? 2 : 0) || turn_o !== 1'(m_turn) ||
          src_active_o !== 1'b0 || busy_o !== 1'b0 || req_count != rc0 + 1) begin
        n_fail++;
        $display("FAIL rnd_after it=%0d: bad_squares=%0d writes=%0d turn=%b act=%b busy=%b reqs=%0d expected 0 %0d %0d 0 0 1",
                 it, bad, wq.size(), turn_o, src_active_o, busy_o, req_count - rc0,
                 (mode == 2) ? 2 : 0, m_turn);
      end
      m_active = 0;
    end
  endtask

  initial begin
    clear_board();
    test_reset();
    test_pawn_move();
    test_ignore_opponent();
    test_relatch_cancel();
    test_timeout();
    test_reject_noise();
    test_king_capture_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
